// File: rtl/twdl_idx_gen.sv
// Twiddle index generator: per-lane numerators k*m and denominator L for a
// mixed-radix FFT stage, built from accumulators, with data aligned by one register.
module twdl_idx_gen #(
  parameter int unsigned wDataInOut = 18,
  parameter int unsigned wIdx       = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic        [2:0]            cfg_factor,
  input  logic        [wIdx-1:0]       cfg_span,
  input  logic                         in_val,
  input  logic                         in_sop,
  input  logic signed [wDataInOut-1:0] din_real [0:4],
  input  logic signed [wDataInOut-1:0] din_imag [0:4],
  output logic                         out_val,
  output logic                         out_sop,
  output logic        [2:0]            factor,
  output logic        [0:4][wIdx-1:0]  twdl_numrtr,
  output logic        [wIdx-1:0]       twdl_demontr,
  output logic signed [wDataInOut-1:0] dout_real [0:4],
  output logic signed [wDataInOut-1:0] dout_imag [0:4],
  output logic                         cfg_err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  factor_q, factor_d;
  logic [wIdx-1:0]             span_q, span_d;
  logic [wIdx-1:0]             acc_q, acc_d;
  logic [0:4][wIdx-1:0]        num_q, num_d;
  logic                        cfg_err_q, cfg_err_d;
  logic                        out_val_q, out_val_d;
  logic                        out_sop_q, out_sop_d;
  logic [0:4][wIdx-1:0]        numrtr_q, numrtr_d;
  logic signed [wDataInOut-1:0] dre_q [0:4];
  logic signed [wDataInOut-1:0] dre_d [0:4];
  logic signed [wDataInOut-1:0] dim_q [0:4];
  logic signed [wDataInOut-1:0] dim_d [0:4];

  logic [wIdx:0] acc_sum;
  logic          cfg_bad;

  always_comb begin
    state_d   = state_q;
    factor_d  = factor_q;
    span_d    = span_q;
    acc_d     = acc_q;
    num_d     = num_q;
    cfg_err_d = cfg_err_q;
    out_val_d = 1'b0;
    out_sop_d = 1'b0;
    numrtr_d  = '0;
    for (int k = 0; k < 5; k++) begin
      dre_d[k] = '0;
      dim_d[k] = '0;
    end

    // One extra bit so acc+r cannot wrap before being compared against L.
    acc_sum = {1'b0, acc_q} + (wIdx+1)'(factor_q);
    cfg_bad = (cfg_factor < 3'd2) || (cfg_factor > 3'd5) ||
              (cfg_span < wIdx'(cfg_factor)) || (cfg_span == '0);

    if (in_val && in_sop) begin
      state_d   = StRun;
      factor_d  = cfg_factor;
      span_d    = cfg_span;
      cfg_err_d = cfg_err_q | cfg_bad;
      out_val_d = 1'b1;
      out_sop_d = 1'b1;
      acc_d     = wIdx'(cfg_factor);
      for (int k = 0; k < 5; k++) begin
        num_d[k] = wIdx'(k);
        dre_d[k] = din_real[k];
        dim_d[k] = din_imag[k];
      end
    end else if (in_val && (state_q == StRun)) begin
      out_val_d = 1'b1;
      for (int k = 0; k < 5; k++) begin
        // Lanes beyond the radix get twiddle 1.
        numrtr_d[k] = (k < int'(factor_q)) ? num_q[k] : '0;
        dre_d[k]    = din_real[k];
        dim_d[k]    = din_imag[k];
      end
      if (acc_sum >= {1'b0, span_q}) begin
        acc_d = '0;
        num_d = '0;
      end else begin
        acc_d = acc_sum[wIdx-1:0];
        for (int k = 0; k < 5; k++) begin
          num_d[k] = num_q[k] + wIdx'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      factor_q  <= 3'd2;
      span_q    <= wIdx'(3);
      acc_q     <= '0;
      num_q     <= '0;
      cfg_err_q <= 1'b0;
      out_val_q <= 1'b0;
      out_sop_q <= 1'b0;
      numrtr_q  <= '0;
      for (int k = 0; k < 5; k++) begin
        dre_q[k] <= '0;
        dim_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      factor_q  <= factor_d;
      span_q    <= span_d;
      acc_q     <= acc_d;
      num_q     <= num_d;
      cfg_err_q <= cfg_err_d;
      out_val_q <= out_val_d;
      out_sop_q <= out_sop_d;
      numrtr_q  <= numrtr_d;
      for (int k = 0; k < 5; k++) begin
        dre_q[k] <= dre_d[k];
        dim_q[k] <= dim_d[k];
      end
    end
  end

  assign out_val      = out_val_q;
  assign out_sop      = out_sop_q;
  assign factor       = factor_q;
  assign twdl_numrtr  = numrtr_q;
  assign twdl_demontr = span_q;
  assign cfg_err      = cfg_err_q;
  assign dout_real    = dre_q;
  assign dout_imag    = dim_q;

endmodule

// File: tb/tb_twdl_idx_gen.sv
// Scoreboard bench for twdl_idx_gen: a beat-index reference model pushes expected
// outputs, a negedge monitor pops and compares whenever out_val is seen.
module tb_twdl_idx_gen;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [2:0]         cfg_factor;
  logic [11:0]        cfg_span;
  logic               in_val, in_sop;
  logic signed [17:0] din_real [0:4];
  logic signed [17:0] din_imag [0:4];
  logic               out_val, out_sop;
  logic [2:0]         factor;
  logic [0:4][11:0]   twdl_numrtr;
  logic [11:0]        twdl_demontr;
  logic signed [17:0] dout_real [0:4];
  logic signed [17:0] dout_imag [0:4];
  logic               cfg_err;

  twdl_idx_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_factor   (cfg_factor),
    .cfg_span     (cfg_span),
    .in_val       (in_val),
    .in_sop       (in_sop),
    .din_real     (din_real),
    .din_imag     (din_imag),
    .out_val      (out_val),
    .out_sop      (out_sop),
    .factor       (factor),
    .twdl_numrtr  (twdl_numrtr),
    .twdl_demontr (twdl_demontr),
    .dout_real    (dout_real),
    .dout_imag    (dout_imag),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             sop;
    logic [4:0][11:0] num;
    logic [4:0][17:0] re;
    logic [4:0][17:0] im;
    logic [2:0]       f;
    logic [11:0]      l;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  bit   mon_en  = 1'b0;
  bit   force_neg = 1'b0;

  // Reference model state: m is the beat index within the current group of L/r beats.
  bit m_run;
  int m_r, m_l, m_m;
  bit m_err;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_r = 2; m_l = 3; m_m = 0; m_err = 1'b0;
  endtask

  // Drive one cycle of stimulus, push its expected response, advance to next negedge.
  task automatic beat(input bit val, input bit sop, input int f, input int s);
    exp_t e;
    in_val     = val;
    in_sop     = sop;
    cfg_factor = 3'(f);
    cfg_span   = 12'(s);
    for (int k = 0; k < 5; k++) begin
      din_real[k] = 18'($urandom);
      din_imag[k] = 18'($urandom);
    end
    if (force_neg) din_real[2] = -18'sd131072;
    e = '0;
    for (int k = 0; k < 5; k++) begin
      e.re[k] = din_real[k];
      e.im[k] = din_imag[k];
    end
    if (val && sop) begin
      if (f < 2 || f > 5 || s < f || s == 0) m_err = 1'b1;
      m_run = 1'b1; m_r = f; m_l = s; m_m = 1;
      e.sop = 1'b1;
      e.f = 3'(m_r); e.l = 12'(m_l); e.err = m_err;
      q.push_back(e);
    end else if (val && m_run) begin
      for (int k = 0; k < 5; k++)
        e.num[k] = (k < m_r) ? 12'((k * m_m) % 4096) : 12'd0;
      e.f = 3'(m_r); e.l = 12'(m_l); e.err = m_err;
      q.push_back(e);
      if ((m_m + 1) * m_r >= m_l) m_m = 0;
      else m_m++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    in_val = 1'b0; in_sop = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_val === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_out_val", 64'(out_val), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_sop", 64'(out_sop), 64'(e.sop));
          chk("factor", 64'(factor), 64'(e.f));
          chk("twdl_demontr", 64'(twdl_demontr), 64'(e.l));
          chk("cfg_err", 64'(cfg_err), 64'(e.err));
          for (int k = 0; k < 5; k++) begin
            chk($sformatf("numrtr%0d", k), 64'(twdl_numrtr[k]), 64'(e.num[k]));
            chk($sformatf("dout_real%0d", k), {46'd0, dout_real[k]}, {46'd0, e.re[k]});
            chk($sformatf("dout_imag%0d", k), {46'd0, dout_imag[k]}, {46'd0, e.im[k]});
          end
        end
      end else begin
        logic nz;
        nz = out_sop | (|twdl_numrtr);
        for (int k = 0; k < 5; k++) nz = nz | (|dout_real[k]) | (|dout_imag[k]);
        chk("idle_outputs_zero", {63'd0, nz} | {63'd0, (out_val !== 1'b0)}, 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, l, n;
    rst_n = 1'b0; in_val = 1'b0; in_sop = 1'b0; cfg_factor = '0; cfg_span = '0;
    for (int k = 0; k < 5; k++) begin din_real[k] = '0; din_imag[k] = '0; end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(3);
    chk("reset_out_val", 64'(out_val), 64'd0);
    chk("reset_factor", 64'(factor), 64'd2);
    chk("reset_demontr", 64'(twdl_demontr), 64'd3);
    chk("reset_cfg_err", 64'(cfg_err), 64'd0);

    // Non-sop beats in idle are ignored.
    beat(1'b1, 1'b0, 4, 16); beat(1'b1, 1'b0, 4, 16); idle(1);

    // r=4, L=16 back-to-back.
    beat(1'b1, 1'b1, 4, 16);
    for (int i = 0; i < 7; i++) beat(1'b1, 1'b0, 0, 0);
    idle(2);

    // r=5, L=20 with 2-cycle gaps, lane2 real at the negative extreme.
    force_neg = 1'b1;
    beat(1'b1, 1'b1, 5, 20); idle(2);
    for (int i = 0; i < 4; i++) begin beat(1'b1, 1'b0, 0, 0); idle(2); end
    force_neg = 1'b0;

    // r=2, L=2048: long count and wrap.
    beat(1'b1, 1'b1, 2, 2048);
    for (int i = 0; i < 1029; i++) beat(1'b1, 1'b0, 0, 0);
    idle(1);

    // Mid-frame sop: r=4 frame interrupted by r=3, L=9.
    beat(1'b1, 1'b1, 4, 16); beat(1'b1, 1'b0, 0, 0); beat(1'b1, 1'b0, 0, 0);
    beat(1'b1, 1'b1, 3, 9);
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 0, 0);
    idle(1);
    chk("midsop_factor", 64'(factor), 64'd3);
    chk("midsop_demontr", 64'(twdl_demontr), 64'd9);

    // L==r==3 still generates numerators.
    beat(1'b1, 1'b1, 3, 3);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 0, 0);

    // Reset mid-frame: beats after reset are dropped until the next sop.
    beat(1'b1, 1'b1, 5, 25); beat(1'b1, 1'b0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 0, 0);
    chk("post_reset_factor", 64'(factor), 64'd2);
    beat(1'b1, 1'b1, 4, 8);
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 0, 0);

    // Randomized legal traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(2, 5);
      l = r * $urandom_range(1, 12);
      n = $urandom_range(0, 3);
      beat(n != 0, (n != 0) && ($urandom_range(0, 15) == 0), r, l);
    end
    idle(1);

    // Illegal radix sets the sticky error until reset.
    beat(1'b1, 1'b1, 6, 12);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 0, 0);
    beat(1'b1, 1'b1, 4, 16); beat(1'b1, 1'b0, 0, 0); idle(1);
    chk("cfg_err_sticky", 64'(cfg_err), 64'd1);
    beat(1'b1, 1'b1, 3, 2); beat(1'b1, 1'b0, 0, 0); idle(1);
    do_reset();
    idle(1);
    chk("cfg_err_cleared", 64'(cfg_err), 64'd0);

    idle(3);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
